// File: rtl/mem_lsu_ctrl_pkg.sv
// Shared definitions for the load/store controller: access-size codes, bus widths,
// FSM state encoding and size decode helpers.
package mem_lsu_ctrl_pkg;

  localparam int          DATA_WIDTH_DEF = 64;
  localparam int          SIGS_WIDTH     = 3;
  localparam logic [63:0] ADDR_SIM       = 64'h0000_0000_8000_0000;

  // Bit 2 selects sign extension, bits [1:0] are log2 of the access size.
  localparam logic [SIGS_WIDTH-1:0] MEM_BYT_1_U = 3'd0;
  localparam logic [SIGS_WIDTH-1:0] MEM_BYT_2_U = 3'd1;
  localparam logic [SIGS_WIDTH-1:0] MEM_BYT_4_U = 3'd2;
  localparam logic [SIGS_WIDTH-1:0] MEM_BYT_8_U = 3'd3;
  localparam logic [SIGS_WIDTH-1:0] MEM_BYT_1_S = 3'd4;
  localparam logic [SIGS_WIDTH-1:0] MEM_BYT_2_S = 3'd5;
  localparam logic [SIGS_WIDTH-1:0] MEM_BYT_4_S = 3'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  // Unknown codes behave as a plain 8-byte access.
  function automatic logic [3:0] byt_size(input logic [SIGS_WIDTH-1:0] byt);
    case (byt)
      MEM_BYT_1_U, MEM_BYT_1_S: byt_size = 4'd1;
      MEM_BYT_2_U, MEM_BYT_2_S: byt_size = 4'd2;
      MEM_BYT_4_U, MEM_BYT_4_S: byt_size = 4'd4;
      default:                  byt_size = 4'd8;
    endcase
  endfunction

  function automatic logic byt_signed(input logic [SIGS_WIDTH-1:0] byt);
    byt_signed = (byt == MEM_BYT_1_S) || (byt == MEM_BYT_2_S) || (byt == MEM_BYT_4_S);
  endfunction

endpackage

// File: rtl/mem_lsu_ctrl_if.sv
// Request/response and memory-port bundle of the load/store controller.
// pLsu_oRespErr exists only when LSU_MISALIGN_CHK_EN is defined.
interface mem_lsu_ctrl_if
  import mem_lsu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                  pLsu_iReqValid;
  logic                  pLsu_oReqReady;
  logic                  pLsu_iReqWr;
  logic [DATA_WIDTH-1:0] pLsu_iReqAddr;
  logic [DATA_WIDTH-1:0] pLsu_iReqData;
  logic [SIGS_WIDTH-1:0] pLsu_iReqByt;
  logic                  pLsu_oRespValid;
  logic [DATA_WIDTH-1:0] pLsu_oRespData;
`ifdef LSU_MISALIGN_CHK_EN
  logic                  pLsu_oRespErr;
`endif
  logic                  pMem_oRdEn;
  logic                  pMem_oWrEn;
  logic [DATA_WIDTH-1:0] pMem_oAddr;
  logic [DATA_WIDTH-1:0] pMem_oWrData;
  logic [SIGS_WIDTH-1:0] pMem_oWrByt;
  logic [DATA_WIDTH-1:0] pMem_iRdData;

  // Controller side: initiator on the memory port, target on the LSU port.
  modport master (
`ifdef LSU_MISALIGN_CHK_EN
    output pLsu_oRespErr,
`endif
    input  pLsu_iReqValid, pLsu_iReqWr, pLsu_iReqAddr, pLsu_iReqData, pLsu_iReqByt,
    output pLsu_oReqReady, pLsu_oRespValid, pLsu_oRespData,
    output pMem_oRdEn, pMem_oWrEn, pMem_oAddr, pMem_oWrData, pMem_oWrByt,
    input  pMem_iRdData
  );

  modport slave (
`ifdef LSU_MISALIGN_CHK_EN
    input  pLsu_oRespErr,
`endif
    output pLsu_iReqValid, pLsu_iReqWr, pLsu_iReqAddr, pLsu_iReqData, pLsu_iReqByt,
    input  pLsu_oReqReady, pLsu_oRespValid, pLsu_oRespData,
    input  pMem_oRdEn, pMem_oWrEn, pMem_oAddr, pMem_oWrData, pMem_oWrByt,
    output pMem_iRdData
  );
endinterface

// File: rtl/mem_lsu_lane.sv
// Byte-lane datapath: extracts and sign/zero-extends load data from a doubleword and
// merges store data into it. Lanes past byte 7 are dropped.
module mem_lsu_lane
  import mem_lsu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [2:0]            off,
  input  logic [SIGS_WIDTH-1:0] byt,
  input  logic [DATA_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] merged
);
  localparam int LANES = DATA_WIDTH / 8;

  logic [3:0]            size;
  logic [7:0]            lanes;
  logic [7:0]            wr_lanes;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] data_sh;
  logic                  sign_bit;
  logic [7:0]            fill;

  // NOTE: every output gets a value on every path, so no latch is inferred.
  always_comb begin
    size     = byt_size(byt);
    lanes    = 8'hFF >> (4'd8 - size);
    wr_lanes = lanes << off;
    shifted  = word >> {off, 3'b000};
    data_sh  = data << {off, 3'b000};
    case (size)
      4'd1:    sign_bit = shifted[7];
      4'd2:    sign_bit = shifted[15];
      4'd4:    sign_bit = shifted[31];
      default: sign_bit = 1'b0;
    endcase
    fill      = (byt_signed(byt) && sign_bit) ? 8'hFF : 8'h00;
    load_data = '0;
    merged    = '0;
    for (int i = 0; i < LANES; i++) begin
      load_data[8*i +: 8] = lanes[i]    ? shifted[8*i +: 8] : fill;
      merged[8*i +: 8]    = wr_lanes[i] ? data_sh[8*i +: 8] : word[8*i +: 8];
    end
  end

endmodule

// File: rtl/mem_lsu_ctrl.sv
// Load/store controller: one request at a time, doubleword read, then write-back of
// the merged word for stores. LSU_MISALIGN_CHK_EN adds a natural-alignment check.
module mem_lsu_ctrl
  import mem_lsu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int MEM_LAT    = 1
) (
  input  logic           iClock,
  input  logic           iReset,
  mem_lsu_ctrl_if.master bus
);
  lsu_state_e            state, state_nxt;
  logic                  req_wr;
  logic [DATA_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic [SIGS_WIDTH-1:0] req_byt;
  logic [DATA_WIDTH-1:0] word;
  logic [3:0]            cnt;
  logic                  accept;
  logic                  rd_done;
  logic                  skip_mem;
  logic                  req_err;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] merged;

  assign accept  = bus.pLsu_iReqValid && bus.pLsu_oReqReady;
  assign rd_done = (state == ST_RD) && (cnt == 4'd0);

`ifdef LSU_MISALIGN_CHK_EN
  assign skip_mem = (bus.pLsu_iReqAddr[2:0] & 3'(byt_size(bus.pLsu_iReqByt) - 4'd1)) != 3'b000;
`else
  assign skip_mem = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state    <= ST_IDLE;
      req_wr   <= 1'b0;
      req_addr <= '0;
      req_data <= '0;
      req_byt  <= '0;
      word     <= '0;
      cnt      <= '0;
      req_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_wr   <= bus.pLsu_iReqWr;
        req_addr <= bus.pLsu_iReqAddr;
        req_data <= bus.pLsu_iReqData;
        req_byt  <= bus.pLsu_iReqByt;
        req_err  <= skip_mem;
        cnt      <= 4'(MEM_LAT - 1);
      end else if (rd_done) begin
        word <= bus.pMem_iRdData;
      end else if (state == ST_RD) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = skip_mem ? ST_RESP : ST_RD;
      ST_RD:   if (cnt == 4'd0) state_nxt = req_wr ? ST_WR : ST_RESP;
      ST_WR:   state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  mem_lsu_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
    .word      (word),
    .off       (req_addr[2:0]),
    .byt       (req_byt),
    .data      (req_data),
    .load_data (load_data),
    .merged    (merged)
  );

  // Outputs are gated by reset so the reset cycle shows all zeros.
  always_comb begin
    bus.pLsu_oReqReady  = !iReset && (state == ST_IDLE);
    bus.pMem_oRdEn      = !iReset && (state == ST_RD);
    bus.pMem_oWrEn      = !iReset && (state == ST_WR);
    bus.pLsu_oRespValid = !iReset && (state == ST_RESP);
    bus.pMem_oAddr      = '0;
    bus.pMem_oWrData    = '0;
    bus.pMem_oWrByt     = '0;
    bus.pLsu_oRespData  = '0;
    if (bus.pMem_oRdEn || bus.pMem_oWrEn) bus.pMem_oAddr = {req_addr[DATA_WIDTH-1:3], 3'b000};
    if (bus.pMem_oWrEn) begin
      bus.pMem_oWrData = merged;
      bus.pMem_oWrByt  = MEM_BYT_8_U;
    end
    if (bus.pLsu_oRespValid && !req_wr && !req_err) bus.pLsu_oRespData = load_data;
  end

`ifdef LSU_MISALIGN_CHK_EN
  assign bus.pLsu_oRespErr = bus.pLsu_oRespValid && req_err;
`endif

endmodule

// File: tb/tb_mem_lsu_ctrl.sv
// Randomized self-checking bench for mem_lsu_ctrl against a byte-level memory model.
module tb_mem_lsu_ctrl;
  import mem_lsu_ctrl_pkg::*;

  localparam int MEM_LAT  = 3;
  localparam int W        = 64;
  localparam int MAX_WAIT = 60;

  logic iClock = 1'b0;
  logic iReset = 1'b1;

  mem_lsu_ctrl_if #(.DATA_WIDTH(W)) bus ();

  mem_lsu_ctrl #(.DATA_WIDTH(W), .MEM_LAT(MEM_LAT)) dut (
    .iClock (iClock),
    .iReset (iReset),
    .bus    (bus)
  );

  always #5 iClock = ~iClock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [63:0] mem     [16];
  logic [63:0] ref_mem [16];
  int          rd_total = 0, wr_total = 0, resp_total = 0, rd_run = 0;
  logic [63:0] last_rd_addr = '0, last_wr_addr = '0, last_wr_data = '0;
  logic [2:0]  last_wr_byt = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge iClock) cyc <= cyc + 1;

  // Memory: read data is valid only in the last cycle of a read burst.
  always @(negedge iClock) begin
    if (bus.pMem_oRdEn) begin
      last_rd_addr = bus.pMem_oAddr;
      rd_total++;
      bus.pMem_iRdData = (rd_run == MEM_LAT - 1) ? mem[bus.pMem_oAddr[6:3]] : {$urandom, $urandom};
      rd_run++;
    end else begin
      rd_run = 0;
      bus.pMem_iRdData = {$urandom, $urandom};
    end
    if (bus.pMem_oWrEn) begin
      wr_total++;
      last_wr_addr = bus.pMem_oAddr;
      last_wr_data = bus.pMem_oWrData;
      last_wr_byt  = bus.pMem_oWrByt;
      mem[bus.pMem_oAddr[6:3]] = bus.pMem_oWrData;
    end
    if (bus.pLsu_oRespValid) resp_total++;
  end

  // Reference: byte-by-byte view of the access rules, updating ref_mem for stores.
  function automatic void model(input logic wr, input logic [63:0] addr, input logic [63:0] data,
                                input logic [2:0] byt, output logic [63:0] exp_data,
                                output logic exp_err, output logic [63:0] exp_word);
    int          size;
    bit          sgn;
    int          off;
    logic [63:0] w, v;
    case (byt)
      MEM_BYT_1_U: begin size = 1; sgn = 0; end
      MEM_BYT_1_S: begin size = 1; sgn = 1; end
      MEM_BYT_2_U: begin size = 2; sgn = 0; end
      MEM_BYT_2_S: begin size = 2; sgn = 1; end
      MEM_BYT_4_U: begin size = 4; sgn = 0; end
      MEM_BYT_4_S: begin size = 4; sgn = 1; end
      default:     begin size = 8; sgn = 0; end
    endcase
    off      = int'(addr[2:0]);
    w        = ref_mem[addr[6:3]];
    exp_err  = 1'b0;
`ifdef LSU_MISALIGN_CHK_EN
    exp_err  = (addr % size) != 0;
`endif
    exp_data = '0;
    exp_word = w;
    if (exp_err) return;
    if (wr) begin
      for (int i = 0; i < size; i++)
        if (off + i < 8) w[8*(off+i) +: 8] = data[8*i +: 8];
      ref_mem[addr[6:3]] = w;
      exp_word = w;
    end else begin
      v = '0;
      for (int i = 0; i < size; i++)
        if (off + i < 8) v[8*i +: 8] = w[8*(off+i) +: 8];
      if (sgn && v[8*size-1]) v = v | ~((64'd1 << (8*size)) - 64'd1);
      exp_data = v;
    end
  endfunction

  task automatic run_req(input string tag, input logic wr, input logic [63:0] addr,
                         input logic [63:0] data, input logic [2:0] byt, output logic [63:0] got);
    logic [63:0] exp_data, exp_word;
    logic        exp_err, got_resp;
    int          rd0, wr0, n_wait, c0, lat, exp_lat;
    got = '0;
    model(wr, addr, data, byt, exp_data, exp_err, exp_word);
    rd0 = rd_total;
    wr0 = wr_total;
    @(negedge iClock);
    bus.pLsu_iReqValid = 1'b1;
    bus.pLsu_iReqWr    = wr;
    bus.pLsu_iReqAddr  = addr;
    bus.pLsu_iReqData  = data;
    bus.pLsu_iReqByt   = byt;
    #1;
    n_wait = 0;
    while (!bus.pLsu_oReqReady && n_wait < MAX_WAIT) begin
      @(negedge iClock); #1;
      n_wait++;
    end
    if (!bus.pLsu_oReqReady) begin
      check({tag, "/ready_timeout"}, 64'd0, 64'd1);
      bus.pLsu_iReqValid = 1'b0;
      return;
    end
    c0 = cyc;
    @(posedge iClock); #1;
    bus.pLsu_iReqValid = 1'b0;
    bus.pLsu_iReqWr    = 1'($urandom);
    bus.pLsu_iReqAddr  = {$urandom, $urandom};
    bus.pLsu_iReqData  = {$urandom, $urandom};
    bus.pLsu_iReqByt   = 3'($urandom);
    got_resp = 1'b0;
    lat      = 0;
    for (int k = 0; k < MAX_WAIT; k++) begin
      @(negedge iClock); #1;
      if (bus.pLsu_oRespValid) begin
        got_resp = 1'b1;
        lat      = cyc - c0;
        got      = bus.pLsu_oRespData;
        break;
      end
    end
    check({tag, "/resp_seen"}, 64'(got_resp), 64'd1);
    exp_lat = exp_err ? 1 : (wr ? MEM_LAT + 2 : MEM_LAT + 1);
    check({tag, "/latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "/data"}, got, exp_data);
`ifdef LSU_MISALIGN_CHK_EN
    check({tag, "/err"}, 64'(bus.pLsu_oRespErr), 64'(exp_err));
`endif
    @(negedge iClock); #1;
    check({tag, "/pulse_one_cycle"}, 64'(bus.pLsu_oRespValid), 64'd0);
    check({tag, "/ready_after"}, 64'(bus.pLsu_oReqReady), 64'd1);
    check({tag, "/rd_cycles"}, 64'(rd_total - rd0), exp_err ? 64'd0 : 64'(MEM_LAT));
    check({tag, "/wr_pulses"}, 64'(wr_total - wr0), (wr && !exp_err) ? 64'd1 : 64'd0);
    if (!exp_err) check({tag, "/rd_addr"}, last_rd_addr, {addr[63:3], 3'b000});
    if (wr && !exp_err) begin
      check({tag, "/wr_addr"}, last_wr_addr, {addr[63:3], 3'b000});
      check({tag, "/wr_data"}, last_wr_data, exp_word);
      check({tag, "/wr_byt"}, 64'(last_wr_byt), 64'(MEM_BYT_8_U));
    end
  endtask

  initial begin
    logic [63:0] got, exp_a, exp_b, got_a, got_b, wa, wb;
    logic        ea, eb;
    int          rd0, wr0, resp0, n_wait, c_b, r_a;
    bit          saw_a;

    for (int i = 0; i < 16; i++) begin
      mem[i]     = {$urandom, $urandom};
      ref_mem[i] = mem[i];
    end
    mem[0] = 64'h8877_6655_4433_2211; ref_mem[0] = mem[0];
    mem[1] = 64'h0123_4567_89AB_CDEF; ref_mem[1] = mem[1];
    mem[2] = 64'h8000_0000_1234_5678; ref_mem[2] = mem[2];

    // A request presented during reset must be ignored.
    bus.pLsu_iReqValid = 1'b1;
    bus.pLsu_iReqWr    = 1'b0;
    bus.pLsu_iReqAddr  = ADDR_SIM;
    bus.pLsu_iReqData  = '0;
    bus.pLsu_iReqByt   = MEM_BYT_8_U;
    bus.pMem_iRdData   = '0;
    repeat (3) @(negedge iClock);
    #1;
    check("reset/ready", 64'(bus.pLsu_oReqReady), 64'd0);
    check("reset/rd_en", 64'(bus.pMem_oRdEn), 64'd0);
    check("reset/wr_en", 64'(bus.pMem_oWrEn), 64'd0);
    check("reset/resp_valid", 64'(bus.pLsu_oRespValid), 64'd0);
    check("reset/addr", bus.pMem_oAddr, 64'd0);
    @(posedge iClock); #1;
    iReset = 1'b0;
    bus.pLsu_iReqValid = 1'b0;
    @(negedge iClock); #1;
    check("reset/ready_after", 64'(bus.pLsu_oReqReady), 64'd1);
    repeat (4) @(negedge iClock);
    check("reset/no_read", 64'(rd_total), 64'd0);

    run_req("ld_1s", 1'b0, ADDR_SIM + 64'hA, {$urandom, $urandom}, MEM_BYT_1_S, got);
    check("ld_1s/const", got, 64'hFFFF_FFFF_FFFF_FFAB);
    run_req("ld_1u", 1'b0, ADDR_SIM + 64'hA, {$urandom, $urandom}, MEM_BYT_1_U, got);
    check("ld_1u/const", got, 64'h0000_0000_0000_00AB);
    run_req("st_2u", 1'b1, ADDR_SIM + 64'hC, 64'h0000_0000_0000_1122, MEM_BYT_2_U, got);
    check("st_2u/const", mem[1], 64'h0123_1122_89AB_CDEF);
    run_req("ld_4s", 1'b0, ADDR_SIM + 64'h14, {$urandom, $urandom}, MEM_BYT_4_S, got);
    check("ld_4s/const", got, 64'hFFFF_FFFF_8000_0000);
    run_req("ld_mis", 1'b0, ADDR_SIM + 64'h2, {$urandom, $urandom}, MEM_BYT_4_U, got);
    run_req("ld_cross", 1'b0, ADDR_SIM + 64'h6, {$urandom, $urandom}, MEM_BYT_4_S, got);
    run_req("st_cross", 1'b1, ADDR_SIM + 64'h1F, 64'hFFFF_FFFF_A5C3_B4D2, MEM_BYT_8_U, got);

    // Reset in the second read cycle of a store aborts it.
    rd0 = rd_total; wr0 = wr_total; resp0 = resp_total;
    @(negedge iClock);
    bus.pLsu_iReqValid = 1'b1;
    bus.pLsu_iReqWr    = 1'b1;
    bus.pLsu_iReqAddr  = ADDR_SIM + 64'h28;
    bus.pLsu_iReqData  = 64'hDEAD_BEEF_CAFE_F00D;
    bus.pLsu_iReqByt   = MEM_BYT_8_U;
    #1;
    check("abort/ready", 64'(bus.pLsu_oReqReady), 64'd1);
    @(posedge iClock); #1;
    bus.pLsu_iReqValid = 1'b0;
    @(negedge iClock);
    @(negedge iClock);
    iReset = 1'b1;
    #1;
    check("abort/ready_in_reset", 64'(bus.pLsu_oReqReady), 64'd0);
    check("abort/rd_en_in_reset", 64'(bus.pMem_oRdEn), 64'd0);
    @(posedge iClock); #1;
    iReset = 1'b0;
    @(negedge iClock); #1;
    check("abort/ready_after", 64'(bus.pLsu_oReqReady), 64'd1);
    repeat (10) @(negedge iClock);
    #1;
    check("abort/no_write", 64'(wr_total - wr0), 64'd0);
    check("abort/no_resp", 64'(resp_total - resp0), 64'd0);
    check("abort/mem_kept", mem[5], ref_mem[5]);

    // Back-to-back loads with valid held high.
    model(1'b0, ADDR_SIM + 64'h30, '0, MEM_BYT_2_S, exp_a, ea, wa);
    model(1'b0, ADDR_SIM + 64'h43, '0, MEM_BYT_1_S, exp_b, eb, wb);
    @(negedge iClock);
    bus.pLsu_iReqValid = 1'b1;
    bus.pLsu_iReqWr    = 1'b0;
    bus.pLsu_iReqAddr  = ADDR_SIM + 64'h30;
    bus.pLsu_iReqByt   = MEM_BYT_2_S;
    #1;
    check("b2b/ready_a", 64'(bus.pLsu_oReqReady), 64'd1);
    @(posedge iClock); #1;
    bus.pLsu_iReqAddr = ADDR_SIM + 64'h43;
    bus.pLsu_iReqByt  = MEM_BYT_1_S;
    saw_a = 0; r_a = 0; c_b = -1; got_a = '0;
    for (n_wait = 0; n_wait < MAX_WAIT; n_wait++) begin
      @(negedge iClock); #1;
      if (bus.pLsu_oRespValid && !saw_a) begin
        saw_a = 1; r_a = cyc; got_a = bus.pLsu_oRespData;
      end
      if (bus.pLsu_oReqReady) begin
        c_b = cyc;
        break;
      end
    end
    check("b2b/resp_a_seen", 64'(saw_a), 64'd1);
    check("b2b/data_a", got_a, exp_a);
    check("b2b/accept_b_cycle", 64'(c_b), 64'(r_a + 1));
    @(posedge iClock); #1;
    bus.pLsu_iReqValid = 1'b0;
    got_b = '0;
    for (n_wait = 0; n_wait < MAX_WAIT; n_wait++) begin
      @(negedge iClock); #1;
      if (bus.pLsu_oRespValid) begin
        got_b = bus.pLsu_oRespData;
        break;
      end
    end
    check("b2b/latency_b", 64'(cyc - c_b), 64'(MEM_LAT + 1));
    check("b2b/data_b", got_b, exp_b);

    for (int t = 0; t < 40; t++) begin
      run_req($sformatf("rand%0d", t), 1'($urandom), ADDR_SIM + 64'($urandom_range(0, 127)),
              {$urandom, $urandom}, 3'($urandom_range(0, 7)), got);
    end

    for (int i = 0; i < 16; i++) check($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
